mvb_encode: RTL



---
 rtl/mvb_pkg.sv | 35 +++
 rtl/mvb_encode_if.sv | 30 +++
 rtl/mvb_check_gen.sv | 33 +++
 rtl/mvb_encode.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mvb_pkg.sv
// MVB transmitter shared definitions.
// States, frame constants, delimiters and check generator polynomial.
package mvb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_DELIM,
    DATA,
    CHECK,
    END_DELIM
  } state_t;

  localparam logic FRAME_MASTER = 1'b0;
  localparam logic FRAME_SLAVE  = 1'b1;

  // Half-bit levels, first half-bit in the MSB.
  localparam logic [17:0] MASTER_DELIM =
    18'b10_11_00_01_11_00_01_01_01;
  localparam logic [17:0] SLAVE_DELIM =
    18'b10_10_10_10_00_11_10_00_11;

  localparam logic [6:0] CRC_POLY = 7'h65;
  localparam int BITS_PER_CHECK_BLOCK = 64;

  function automatic logic len_ok(
    input logic       ft,
    input logic [4:0] n
  );
    if (ft == FRAME_MASTER)
      return n == 5'd1;
    return n inside {5'd1, 5'd2, 5'd4,
                     5'd8, 5'd16};
  endfunction

endpackage

// File: rtl/mvb_encode_if.sv
// Host-side request/word handshake of the MVB transmitter.
// master = host/FIFO side, slave = encoder side.
interface mvb_encode_if;
  logic        tx_start;
  logic        frame_type;
  logic [4:0]  frame_length;
  logic [15:0] word_in;
  logic        word_valid;
  logic        word_ack;
  logic        busy;
  logic        tx_done;
  logic        length_error;
  logic        underrun_error;

  modport master (
    output tx_start, frame_type,
    output frame_length, word_in,
    output word_valid,
    input  word_ack, busy, tx_done,
    input  length_error, underrun_error
  );

  modport slave (
    input  tx_start, frame_type,
    input  frame_length, word_in,
    input  word_valid,
    output word_ack, busy, tx_done,
    output length_error, underrun_error
  );
endinterface

// File: rtl/mvb_check_gen.sv
// Serial MVB check sequence generator.
// 7-bit BCH remainder plus even parity, all inverted.
module mvb_check_gen
  import mvb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic [7:0] check
);

  logic [6:0] crc;
  logic       par;
  logic       fb;

  assign fb = bit_in ^ crc[6];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= '0;
      par <= 1'b0;
    end else if (shift_en) begin
      crc <= {crc[5:0], 1'b0}
           ^ (fb ? CRC_POLY : 7'h00);
      par <= par ^ bit_in;
    end
  end

  assign check = ~{crc, par ^ (^crc)};

endmodule

// File: rtl/mvb_encode.sv
// MVB frame transmitter: start delimiter, data words,
// check bytes and end delimiter on a Manchester line.
module mvb_encode
  import mvb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  mvb_encode_if.slave host,
  output logic data_out,
  output logic tx_en
);

  state_t      state, state_n;
  logic [3:0]  clk_cnt, clk_n;
  logic [5:0]  bit_cnt, bit_n;
  logic [4:0]  word_cnt, word_n;
  logic [4:0]  len, len_n;
  logic        ftype, ft_n;
  logic [15:0] shreg, sh_n;
  logic        aborted, ab_n;
  logic        lerr, lerr_n;

  logic ack, under, done;
  logic crc_clr, crc_sh;
  logic bit_end, wstart, cur_bit;
  logic [7:0]  check;
  logic [17:0] pat;
  logic [4:0]  pidx;

  assign bit_end = clk_cnt == 4'd15;
  assign wstart  = clk_cnt == 4'd0
                && bit_cnt[3:0] == 4'd0;
  assign cur_bit = wstart ? host.word_in[15]
                          : shreg[15];

  mvb_check_gen u_check (
    .clk      (clk),
    .rst      (rst),
    .clear    (crc_clr),
    .shift_en (crc_sh),
    .bit_in   (shreg[15]),
    .check    (check)
  );

  always_comb begin
    state_n = state;
    clk_n   = clk_cnt + 4'd1;
    bit_n   = bit_cnt;
    word_n  = word_cnt;
    len_n   = len;
    ft_n    = ftype;
    sh_n    = shreg;
    ab_n    = aborted;
    lerr_n  = 1'b0;
    crc_clr = 1'b0;
    crc_sh  = 1'b0;
    ack     = 1'b0;
    under   = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        clk_n  = '0;
        bit_n  = '0;
        word_n = '0;
        if (host.tx_start) begin
          if (len_ok(host.frame_type,
                     host.frame_length)) begin
            state_n = START_DELIM;
            len_n   = host.frame_length;
            ft_n    = host.frame_type;
            ab_n    = 1'b0;
            crc_clr = 1'b1;
          end else begin
            lerr_n = 1'b1;
          end
        end
      end
      START_DELIM: begin
        if (bit_end) begin
          bit_n = bit_cnt + 6'd1;
          if (bit_cnt == 6'd8) begin
            state_n = DATA;
            bit_n   = '0;
            crc_clr = 1'b1;
          end
        end
      end
      DATA: begin
        if (wstart) begin
          if (host.word_valid) begin
            ack  = 1'b1;
            sh_n = host.word_in;
          end else begin
            // Abort straight into the end delimiter.
            under   = 1'b1;
            ab_n    = 1'b1;
            state_n = END_DELIM;
            clk_n   = '0;
            bit_n   = '0;
          end
        end
        if (bit_end) begin
          crc_sh = 1'b1;
          sh_n   = {shreg[14:0], 1'b0};
          bit_n  = bit_cnt + 6'd1;
          if (bit_cnt[3:0] == 4'd15)
            word_n = word_cnt + 5'd1;
          if (bit_cnt == 6'd63
              || (bit_cnt[3:0] == 4'd15
                  && word_cnt == len - 5'd1)) begin
            state_n = CHECK;
            bit_n   = '0;
          end
        end
      end
      CHECK: begin
        if (bit_end) begin
          bit_n = bit_cnt + 6'd1;
          if (bit_cnt == 6'd7) begin
            bit_n = '0;
            if (word_cnt == len) begin
              state_n = END_DELIM;
            end else begin
              state_n = DATA;
              crc_clr = 1'b1;
            end
          end
        end
      end
      END_DELIM: begin
        if (bit_end) begin
          state_n = IDLE;
          done    = !aborted;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      len      <= '0;
      ftype    <= 1'b0;
      shreg    <= '0;
      aborted  <= 1'b0;
      lerr     <= 1'b0;
    end else begin
      state    <= state_n;
      clk_cnt  <= clk_n;
      bit_cnt  <= bit_n;
      word_cnt <= word_n;
      len      <= len_n;
      ftype    <= ft_n;
      shreg    <= sh_n;
      aborted  <= ab_n;
      lerr     <= lerr_n;
    end
  end

  assign pat  = ftype ? SLAVE_DELIM : MASTER_DELIM;
  assign pidx = 5'd17 - {bit_cnt[3:0], clk_cnt[3]};

  always_comb begin
    data_out = 1'b0;
    unique case (state)
      START_DELIM: data_out = pat[pidx];
      DATA:
        if (!(wstart && !host.word_valid))
          data_out = cur_bit ^ clk_cnt[3];
      CHECK:
        data_out = check[3'd7 - bit_cnt[2:0]]
                 ^ clk_cnt[3];
      default: data_out = 1'b0;
    endcase
  end

  assign tx_en               = state != IDLE;
  assign host.busy           = state != IDLE;
  assign host.word_ack       = ack;
  assign host.underrun_error = under;
  assign host.tx_done        = done;
  assign host.length_error   = lerr;

endmodule
